dice_roller: RTL and testbench

- Upstream stage of the dice-game scorer: turns the two players' raw push-buttons into settled dice values plus start strobes.
- Outputs feed the scorer's dice1/dice2/start1/start2 inputs directly.
- Per player: debounce the key, run a visible "rolling" animation on the dice value, then settle on a pseudo-random face 1..6 and pulse start.
- One shared LFSR supplies randomness.

---
 rtl/dice_roller.sv | 155 +++++++++++++++
 tb/tb_dice_roller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dice_roller.sv
// Two-player dice front end: debounces each key, animates a roll, then settles
// on an LFSR-derived face 1..6 with a one-cycle start strobe.
module dice_roller #(
  parameter int unsigned DEB_CNT    = 1_000_000,
  parameter int unsigned TICK_DIV   = 5_000_000,
  parameter int unsigned ROLL_STEPS = 12,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key1,
  input  logic       key2,
  output logic [3:0] dice1,
  output logic [3:0] dice2,
  output logic       rolling1,
  output logic       rolling2,
  output logic       start1,
  output logic       start2
);

  localparam int unsigned NP         = 2;
  localparam int unsigned DEB_W      = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam int unsigned TICK_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned STEP_W     = (ROLL_STEPS > 1) ? $clog2(ROLL_STEPS) : 1;
  // The press-accept cycle is the first animation cycle of the roll.
  localparam int unsigned TICK_FIRST = (TICK_DIV > 1) ? 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_ROLL, S_HOLD} state_e;

  logic [NP-1:0]     key_c;
  logic [NP-1:0]     sync1_q, sync2_q;
  logic [NP-1:0]     deb_q, deb_d, deb_dly_q, arm_q, arm_d, press_q, press_d;
  logic [DEB_W-1:0]  dcnt_q [NP];
  logic [DEB_W-1:0]  dcnt_d [NP];
  logic [15:0]       lfsr_q, lfsr_d;
  logic [3:0]        face_c [NP];
  state_e            state_q [NP];
  state_e            state_d [NP];
  logic [TICK_W-1:0] tick_q [NP];
  logic [TICK_W-1:0] tick_d [NP];
  logic [STEP_W-1:0] step_q [NP];
  logic [STEP_W-1:0] step_d [NP];
  logic [3:0]        dice_q [NP];
  logic [3:0]        dice_d [NP];
  logic [NP-1:0]     rolling_q, rolling_d, start_q, start_d;

  assign key_c = {key2, key1};

  // Two-flop synchroniser; left unreset so a key held through reset stays visible.
  always_ff @(posedge clk) begin
    sync1_q <= key_c;
    sync2_q <= sync1_q;
  end

  // Debounce, press detect and arming: a press is only honoured once the
  // synced key has been seen low since reset, so a held key cannot re-roll.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      deb_d[p]  = deb_q[p];
      dcnt_d[p] = '0;
      if (sync2_q[p] != deb_q[p]) begin
        if (dcnt_q[p] == DEB_W'(DEB_CNT - 1)) deb_d[p] = sync2_q[p];
        else                                  dcnt_d[p] = dcnt_q[p] + DEB_W'(1);
      end
    end
    arm_d   = arm_q | ~sync2_q;
    press_d = deb_q & ~deb_dly_q & arm_q;
  end

  assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign face_c[0] = 4'(lfsr_q[7:0] % 8'd6) + 4'd1;
  assign face_c[1] = 4'(lfsr_q[15:8] % 8'd6) + 4'd1;

  // Per-player roll FSM: next state plus registered-output next values.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      state_d[p] = state_q[p];
      tick_d[p]  = tick_q[p];
      step_d[p]  = step_q[p];
      dice_d[p]  = dice_q[p];
      start_d[p] = 1'b0;
      unique case (state_q[p])
        S_IDLE: begin
          if (press_q[p]) begin
            state_d[p] = S_ROLL;
            tick_d[p]  = TICK_W'(TICK_FIRST);
            step_d[p]  = '0;
          end
        end
        S_ROLL: begin
          if (tick_q[p] == TICK_W'(TICK_DIV - 1)) begin
            tick_d[p] = '0;
            if (step_q[p] == STEP_W'(ROLL_STEPS - 1)) begin
              dice_d[p]  = face_c[p];
              start_d[p] = 1'b1;
              state_d[p] = S_HOLD;
            end else begin
              dice_d[p] = (dice_q[p] >= 4'd6) ? 4'd1 : dice_q[p] + 4'd1;
              step_d[p] = step_q[p] + STEP_W'(1);
            end
          end else begin
            tick_d[p] = tick_q[p] + TICK_W'(1);
          end
        end
        S_HOLD: begin
          if (!deb_q[p]) state_d[p] = S_IDLE;
        end
        default: state_d[p] = S_IDLE;
      endcase
      rolling_d[p] = (state_d[p] == S_ROLL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q     <= '0;
      deb_dly_q <= '0;
      arm_q     <= '0;
      press_q   <= '0;
      lfsr_q    <= LFSR_SEED;
      rolling_q <= '0;
      start_q   <= '0;
      for (int p = 0; p < NP; p++) begin
        dcnt_q[p]  <= '0;
        state_q[p] <= S_IDLE;
        tick_q[p]  <= '0;
        step_q[p]  <= '0;
        dice_q[p]  <= '0;
      end
    end else begin
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      arm_q     <= arm_d;
      press_q   <= press_d;
      lfsr_q    <= lfsr_d;
      rolling_q <= rolling_d;
      start_q   <= start_d;
      for (int p = 0; p < NP; p++) begin
        dcnt_q[p]  <= dcnt_d[p];
        state_q[p] <= state_d[p];
        tick_q[p]  <= tick_d[p];
        step_q[p]  <= step_d[p];
        dice_q[p]  <= dice_d[p];
      end
    end
  end

  assign dice1    = dice_q[0];
  assign dice2    = dice_q[1];
  assign rolling1 = rolling_q[0];
  assign rolling2 = rolling_q[1];
  assign start1   = start_q[0];
  assign start2   = start_q[1];

endmodule

// File: tb/tb_dice_roller.sv
// Scoreboard bench for dice_roller: stimulus queues expected rolls, a negedge
// monitor replays them against the outputs every cycle.
module tb_dice_roller;

  localparam int DEB   = 4;
  localparam int TICK  = 3;
  localparam int STEPS = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct {
    int         pc;    // edge at which the press is registered
    logic [3:0] face;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key1_r = 1'b0, key2_r = 1'b0;
  logic [3:0] dice1, dice2;
  logic       rolling1, rolling2, start1, start2;

  int   edge_n = 0;
  int   last_rst = 0;
  bit   rst_seen = 1'b0;
  exp_t sbq [2][$];
  int   m_dice [2];
  int   checks = 0;
  int   errors = 0;
  bit   timeout_req = 1'b0;
  bit   timeout_seen = 1'b0;

  dice_roller #(.DEB_CNT(DEB), .TICK_DIV(TICK), .ROLL_STEPS(STEPS), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .key1(key1_r), .key2(key2_r),
    .dice1(dice1), .dice2(dice2), .rolling1(rolling1), .rolling2(rolling2),
    .start1(start1), .start2(start2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    edge_n   <= edge_n + 1;
    rst_seen <= rst;
    if (rst) last_rst <= edge_n + 1;
  end

  // LFSR contents just after edge n, stepped from the seed since the last reset.
  function automatic logic [15:0] lfsr_after(int n);
    logic [15:0] v = SEED;
    for (int i = 0; i < n - last_rst; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    return v;
  endfunction

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setkey(int p, logic v);
    if (p == 0) key1_r = v;
    else        key2_r = v;
  endtask

  // Clean press: first sampled at the next edge, held for 'hold' cycles.
  task automatic press(int p, int hold);
    exp_t        e;
    logic [15:0] l;
    logic [7:0]  b;
    setkey(p, 1'b1);
    e.pc = edge_n + 1 + DEB + 2;
    l = lfsr_after(e.pc + STEPS * TICK - 1);
    b = (p == 0) ? l[7:0] : l[15:8];
    e.face = 4'(b % 8'd6) + 4'd1;
    sbq[p].push_back(e);
    cyc(hold);
    setkey(p, 1'b0);
  endtask

  task automatic glitch(int p, int hi);
    setkey(p, 1'b1);
    cyc(hi);
    setkey(p, 1'b0);
    cyc(3);
  endtask

  task automatic chk(string nm, int p, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s p%0d edge=%0d got=%0d exp=%0d", nm, p, edge_n, got, exp);
    end
  endtask

  // Monitor: advance the expected per-player view and compare every cycle.
  always @(negedge clk) begin
    if (edge_n > 0) begin
      for (int p = 0; p < 2; p++) begin
        automatic int e_roll = 0;
        automatic int e_start = 0;
        automatic int d;
        if (rst_seen) begin
          sbq[p].delete();
          m_dice[p] = 0;
        end else if (sbq[p].size() > 0) begin
          d = edge_n - sbq[p][0].pc;
          e_roll = (d > 0 && d < STEPS * TICK) ? 1 : 0;
          if (d > 0 && d % TICK == 0) begin
            if (d / TICK < STEPS) m_dice[p] = m_dice[p] % 6 + 1;
            else begin
              m_dice[p] = int'(sbq[p][0].face);
              e_start   = 1;
              void'(sbq[p].pop_front());
            end
          end
        end
        chk("dice",    p, int'(p == 0 ? dice1 : dice2), m_dice[p]);
        chk("rolling", p, int'(p == 0 ? rolling1 : rolling2), e_roll);
        chk("start",   p, int'(p == 0 ? start1 : start2), e_start);
      end
      if (timeout_req && !timeout_seen) begin
        timeout_seen = 1'b1;
        checks++;
        errors++;
        $display("FAIL scoreboard_drain edge=%0d got=%0d,%0d pending exp=0", edge_n,
                 sbq[0].size(), sbq[1].size());
      end
    end
  end

  task automatic random_player(int p);
    for (int r = 0; r < 6; r++) begin
      for (int g = 0; g < int'($urandom_range(2, 0)); g++) glitch(p, int'($urandom_range(DEB - 1, 1)));
      press(p, int'($urandom_range(35, 20)));
      cyc(int'($urandom_range(16, 8)));
    end
  endtask

  initial begin
    m_dice[0] = 0;
    m_dice[1] = 0;
    cyc(2);
    rst = 1'b0;
    cyc(3);

    // Bounce train shorter than the debounce window.
    for (int i = 0; i < 6; i++) begin
      key1_r = 1'b1; cyc(3);
      key1_r = 1'b0; cyc(2);
    end
    cyc(6);

    // Clean press held well past the settle.
    press(0, 40);
    cyc(10);

    // Release/re-press during the roll is ignored; a later press rolls again.
    key1_r = 1'b1;
    begin
      exp_t e;
      logic [15:0] l;
      e.pc = edge_n + 1 + DEB + 2;
      l = lfsr_after(e.pc + STEPS * TICK - 1);
      e.face = 4'(l[7:0] % 8'd6) + 4'd1;
      sbq[0].push_back(e);
    end
    cyc(6);  key1_r = 1'b0;
    cyc(5);  key1_r = 1'b1;
    cyc(30); key1_r = 1'b0;
    cyc(10);
    press(0, 25);
    cyc(10);

    // Both players on the same cycle.
    fork
      press(0, 30);
      press(1, 30);
    join
    cyc(10);

    // Reset mid-roll with the key still held; only a fresh press rolls.
    key1_r = 1'b1;
    begin
      exp_t e;
      e.pc = edge_n + 1 + DEB + 2;
      e.face = 4'd0;
      sbq[0].push_back(e);
    end
    cyc(13); rst = 1'b1;
    cyc(1);  rst = 1'b0;
    cyc(27); key1_r = 1'b0;
    cyc(10);
    press(0, 25);
    cyc(10);

    fork
      random_player(0);
      random_player(1);
    join

    for (int i = 0; i < 200 && (sbq[0].size() > 0 || sbq[1].size() > 0); i++) cyc(1);
    if (sbq[0].size() > 0 || sbq[1].size() > 0) timeout_req = 1'b1;
    cyc(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
